// File: rtl/mux_sel_buffered.sv
// N-way selector feeding a 2-entry valid/ready skid buffer.
// Out-of-range selectors forward input 0 and are flagged per entry and in a sticky bit.
module mux_sel_buffered #(
  parameter int unsigned N_INPUTS = 7,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEL_W-1:0]             selector,
  input  logic [N_INPUTS*DATA_W-1:0]   data_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            data_out,
  output logic [SEL_W-1:0]             out_sel,
  output logic                         out_err,
  output logic                         err_sticky,
  input  logic                         err_clr
);

  localparam int unsigned CMP_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [SEL_W-1:0]  head_sel_q,  head_sel_d;
  logic              head_err_q,  head_err_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0]  skid_sel_q,  skid_sel_d;
  logic              skid_err_q,  skid_err_d;
  logic              err_sticky_q, err_sticky_d;

  logic              accept;
  logic              pop;
  logic [DATA_W-1:0] new_data;
  logic              new_err;

  // Input selection; anything not matching an in-range index falls back to input 0.
  always_comb begin
    new_data = data_in[DATA_W-1:0];
    for (int unsigned k = 1; k < N_INPUTS; k++) begin
      if (selector == SEL_W'(k)) begin
        new_data = data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  assign new_err   = (CMP_W'(selector) >= N_INPUTS);

  // Ready depends only on registered occupancy, held low while in reset.
  assign in_ready  = reset & (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign data_out   = head_data_q;
  assign out_sel    = head_sel_q;
  assign out_err    = head_err_q;
  assign err_sticky = err_sticky_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_EMPTY;
      head_data_q  <= '0;
      head_sel_q   <= '0;
      head_err_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      skid_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_data_q  <= head_data_d;
      head_sel_q   <= head_sel_d;
      head_err_q   <= head_err_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      skid_err_q   <= skid_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Occupancy FSM and buffer movement; head keeps its last value when drained.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sel_d  = head_sel_q;
    head_err_d  = head_err_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    skid_err_d  = skid_err_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_data_d = new_data;
          head_sel_d  = selector;
          head_err_d  = new_err;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          head_data_d = new_data;
          head_sel_d  = selector;
          head_err_d  = new_err;
        end else if (accept) begin
          skid_data_d = new_data;
          skid_sel_d  = selector;
          skid_err_d  = new_err;
          state_d     = ST_FULL;
        end else if (pop) begin
          state_d     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          head_data_d = skid_data_q;
          head_sel_d  = skid_sel_q;
          head_err_d  = skid_err_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // A new out-of-range accept beats a simultaneous clear.
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (accept && new_err) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end
  end

endmodule
